id_stage_fwd: RTL
=================

# id_stage_fwd

Parametrised decode stage for the pipelined RISC-V core. It holds the architectural register file, forwards operands from the EX, MEM and WB stages, and detects load-use hazards, stalling the fetch side for them. It resolves JAL/JALR targets in decode and issues a redirect to fetch. It sits between the IF/ID and ID/EX boundaries, with a valid/ready handshake on both sides and a registered output toward EX.

## Interface
- XLEN, 32, datapath and PC width
- NREG, 32, register count; AW = $clog2(NREG) is the register-index width
- CNTW, 16, width of the saturating stall counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_pc  in  XLEN  instruction PC
- if_rs1, if_rs2, if_rd  in  AW  register indices
- if_use_rs1, if_use_rs2  in  1  instruction reads rs1 / rs2
- if_b_imm, if_j_imm, if_i_imm  in  XLEN  sign-extended immediates
- if_jb_sel  in  2  00 branch, 01 JAL, 1x JALR
- if_jump  in  1  unconditional jump; resolve and redirect in ID
- ex_valid, ex_we, ex_is_load  in  1  EX-stage instruction status
- ex_rd  in  AW  EX destination
- ex_data  in  XLEN  EX ALU result
- mem_we  in  1  MEM-stage write
- mem_rd  in  AW  MEM destination
- mem_data  in  XLEN  MEM result
- wb_we  in  1  WB register-file write
- wb_rd  in  AW  WB destination
- wb_data  in  XLEN  WB result
- flush  in  1  EX branch mispredict; kill the ID contents
- ex_ready  in  1  EX accepts the ID output
- id_valid  out  1  output register holds an instruction
- id_pc  out  XLEN  PC of the held instruction
- id_rs1_val, id_rs2_val  out  XLEN  forwarded operands
- id_rd  out  AW  destination index
- id_tgt  out  XLEN  computed jump/branch target
- redirect  out  1  one-cycle fetch redirect
- redirect_pc  out  XLEN  redirect target
- stall_cnt  out  CNTW  count of load-use stall cycles, saturating

## Operation
- Register file:
  - NREG x XLEN.
  - Write on the rising edge when wb_we and wb_rd != 0.
  - x0 always reads as 0.
  - All entries clear on reset.
- Operand select, per source, highest priority first:
  1. Index 0 gives 0.
  2. ex_valid & ex_we & !ex_is_load & ex_rd match gives ex_data.
  3. mem_we & mem_rd match gives mem_data.
  4. wb_we & wb_rd match gives wb_data.
  5. Otherwise the register-file read.
- Load-use hazard (hz):
  - Set when if_valid & ex_valid & ex_is_load & ex_rd != 0, and (if_use_rs1 & if_rs1 == ex_rd) or (if_use_rs2 & if_rs2 == ex_rd).
  - An unused source never stalls.
- Target computation:
  - imm = b_imm for sel 00, j_imm for 01, i_imm for 1x.
  - base = forwarded rs1 when if_jb_sel[1] is set, otherwise if_pc.
  - tgt = (base + imm) mod 2^XLEN.
  - For JALR, bit 0 of tgt is cleared.
- Handshake:
  - adv = !id_valid | ex_ready.
  - if_ready = adv & !hz & !redirect.
  - accept = if_valid & if_ready & !flush.
- Output register, updated on every edge where adv holds or flush is asserted:
  - flush: id_valid <= 0.
  - Else accept: id_valid <= 1, and all payload fields are loaded.
  - Else: id_valid <= 0, which inserts a bubble on a hazard or when no instruction is offered.
  - When !adv & !flush, the register holds its value.
- Redirect:
  - On accept & if_jump: redirect <= 1 and redirect_pc <= tgt on the next edge, for exactly one cycle.
  - While redirect = 1, if_ready = 0, so the wrong-path fetch is dropped.
  - flush in the same cycle suppresses the redirect.
- stall_cnt increments on every cycle where hz & adv holds, and saturates at 2^CNTW - 1.

## Timing
- Reset (rst_n = 0, asynchronous): id_valid = 0, redirect = 0, stall_cnt = 0, all data outputs 0, register file 0.
- Accept-to-output latency is 1 cycle; redirect is asserted 1 cycle after accepting a jump.
- A WB write and an ID read of the same register in the same cycle return wb_data (write-through).
- A load-use hazard costs exactly 1 bubble: the next cycle has the load in MEM, so the value comes via mem_data. This assumes mem_data carries load data.
- Downstream backpressure (!ex_ready while id_valid): all outputs stay stable, if_ready = 0, and hz is not counted.
- flush together with a hazard, a jump, or backpressure: flush wins, id_valid = 0 next cycle, and no redirect is issued.
- Reset asserted mid-stall or mid-redirect clears everything immediately; there is no residual redirect.
- x0 as a destination in any stage is never forwarded and never stalls.

## Test plan
- Basic flow:
  - Stimulus: wb writes x5 = 0x11 at cycle 0; at cycle 1 issue an add reading x5, x0.
  - Required: at cycle 2, id_valid = 1, id_rs1_val = 0x11, id_rs2_val = 0.
- Forwarding priority:
  - Stimulus: ex_rd = mem_rd = wb_rd = 3 with data 0xA, 0xB, 0xC; instruction reads x3.
  - Required: operand 0xA. With ex_we = 0 it is 0xB; with mem_we = 0 as well it is 0xC.
- Load-use:
  - Stimulus: ex_is_load on x7; instruction uses rs2 = 7.
  - Required: one cycle with if_ready = 0 and id_valid = 0 next, stall_cnt = 1; the instruction is accepted the following cycle with mem_data forwarded.
  - Same stimulus with if_use_rs2 = 0: no stall.
- JALR:
  - Stimulus: rs1 = 0x1001, i_imm = 0x10, if_jump = 1.
  - Required: id_tgt = 0x1010, redirect pulse 1 cycle with redirect_pc = 0x1010, and if_ready = 0 during the pulse.
  - JAL at pc 0x100 with j_imm = -4 gives 0xFC.
- Flush and backpressure:
  - Stimulus: hold ex_ready = 0 for 3 cycles.
  - Required: outputs frozen.
  - Stimulus: assert flush with a jump being accepted.
  - Required: id_valid = 0, no redirect.
  - Stimulus: assert rst_n = 0 mid-redirect.
  - Required: redirect drops immediately.
- Saturation:
  - Stimulus: CNTW = 2; run 5 hazard cycles.
  - Required: stall_cnt = 3.

Source files
------------

// File: rtl/id_stage_fwd.sv
// rtl/id_stage_fwd.sv - RISC-V decode stage: register file, operand forwarding,
// load-use stall detection, JAL/JALR resolution and registered ID/EX output.
module id_stage_fwd #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int CNTW = 16,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [XLEN-1:0] if_pc_i,
   input  logic [AW-1:0]   if_rs1_i,
   input  logic [AW-1:0]   if_rs2_i,
   input  logic [AW-1:0]   if_rd_i,
   input  logic            if_use_rs1_i,
   input  logic            if_use_rs2_i,
   input  logic [XLEN-1:0] if_b_imm_i,
   input  logic [XLEN-1:0] if_j_imm_i,
   input  logic [XLEN-1:0] if_i_imm_i,
   input  logic [1:0]      if_jb_sel_i,
   input  logic            if_jump_i,
   input  logic            ex_valid_i,
   input  logic            ex_we_i,
   input  logic            ex_is_load_i,
   input  logic [AW-1:0]   ex_rd_i,
   input  logic [XLEN-1:0] ex_data_i,
   input  logic            mem_we_i,
   input  logic [AW-1:0]   mem_rd_i,
   input  logic [XLEN-1:0] mem_data_i,
   input  logic            wb_we_i,
   input  logic [AW-1:0]   wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            flush_i,
   input  logic            ex_ready_i,
   output logic            id_valid_o,
   output logic [XLEN-1:0] id_pc_o,
   output logic [XLEN-1:0] id_rs1_val_o,
   output logic [XLEN-1:0] id_rs2_val_o,
   output logic [AW-1:0]   id_rd_o,
   output logic [XLEN-1:0] id_tgt_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic [CNTW-1:0] stall_cnt_o
);

   logic [XLEN-1:0] rf_q [NREG];
   logic            id_valid_q, redirect_q, redirect_d;
   logic [XLEN-1:0] id_pc_q, id_rs1_q, id_rs2_q, id_tgt_q, redirect_pc_q;
   logic [AW-1:0]   id_rd_q;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   logic [XLEN-1:0] rs1_val, rs2_val, imm, base, tgt;
   logic            hz, adv, accept;

   // Loads in EX are excluded: their data only exists once the load reaches MEM.
   function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] idx, input logic [XLEN-1:0] rf_val);
      if (idx == '0)                                                  return '0;
      else if (ex_valid_i && ex_we_i && !ex_is_load_i && ex_rd_i == idx) return ex_data_i;
      else if (mem_we_i && mem_rd_i == idx)                            return mem_data_i;
      else if (wb_we_i && wb_rd_i == idx)                              return wb_data_i;
      else                                                             return rf_val;
   endfunction

   always_comb begin
      rs1_val = fwd(if_rs1_i, rf_q[if_rs1_i]);
      rs2_val = fwd(if_rs2_i, rf_q[if_rs2_i]);
      hz = if_valid_i && ex_valid_i && ex_is_load_i && (ex_rd_i != '0) &&
           ((if_use_rs1_i && if_rs1_i == ex_rd_i) || (if_use_rs2_i && if_rs2_i == ex_rd_i));
      case (if_jb_sel_i)
         2'b00:   imm = if_b_imm_i;
         2'b01:   imm = if_j_imm_i;
         default: imm = if_i_imm_i;
      endcase
      base = if_jb_sel_i[1] ? rs1_val : if_pc_i;
      tgt  = base + imm;
      if (if_jb_sel_i[1]) tgt[0] = 1'b0;
      adv         = !id_valid_q || ex_ready_i;
      if_ready_o  = adv && !hz && !redirect_q;
      accept      = if_valid_i && if_ready_o && !flush_i;
      redirect_d  = accept && if_jump_i;
      stall_cnt_d = stall_cnt_q;
      if (hz && adv && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         id_valid_q    <= 1'b0;
         id_pc_q       <= '0;
         id_rs1_q      <= '0;
         id_rs2_q      <= '0;
         id_rd_q       <= '0;
         id_tgt_q      <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         if (wb_we_i && wb_rd_i != '0) rf_q[wb_rd_i] <= wb_data_i;
         if (flush_i) begin
            id_valid_q <= 1'b0;
         end else if (adv) begin
            id_valid_q <= accept;
            if (accept) begin
               id_pc_q  <= if_pc_i;
               id_rs1_q <= rs1_val;
               id_rs2_q <= rs2_val;
               id_rd_q  <= if_rd_i;
               id_tgt_q <= tgt;
            end
         end
         redirect_q <= redirect_d;
         if (redirect_d) redirect_pc_q <= tgt;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign id_valid_o    = id_valid_q;
   assign id_pc_o       = id_pc_q;
   assign id_rs1_val_o  = id_rs1_q;
   assign id_rs2_val_o  = id_rs2_q;
   assign id_rd_o       = id_rd_q;
   assign id_tgt_o      = id_tgt_q;
   assign redirect_o    = redirect_q;
   assign redirect_pc_o = redirect_pc_q;
   assign stall_cnt_o   = stall_cnt_q;

endmodule
